// File: rtl/gates_selftest.sv
// Self-test sequencer for a six-gate logic block: sweeps {A,B} through 00..11,
// waits for LEDR to settle, and accumulates sticky mismatch information.
//
// state  | meaning
// IDLE   | waiting for START after reset
// DRIVE  | register A/B from the vector index, load the settle timer
// SETTLE | down-count the settle timer until it reaches zero
// CHECK  | compare LEDR with the expected gate outputs, advance or finish
// FINISH | results valid on DONE/PASS/FAIL; restart on START or LOOP
`timescale 1ns/1ps
module gates_selftest #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          LOOP          = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [5:0] LEDR,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic       FAIL,
  output logic [3:0] ERR_VEC,
  output logic [5:0] ERR_BITS
);

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, FINISH} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       armed;
  logic [5:0] exp_ledr;
  logic [5:0] diff;
  logic [3:0] vec_hit;
  logic [3:0] err_vec_nxt;
  logic       start_ok;

  always_comb begin
    exp_ledr    = {~(A ^ B), A ^ B, ~(A | B), ~(A & B), A | B, A & B};
    diff        = LEDR ^ exp_ledr;
    vec_hit     = 4'b0001 << idx;
    err_vec_nxt = (|diff) ? (ERR_VEC | vec_hit) : ERR_VEC;
    // armed stays low for the first edge after reset release, so a START
    // coincident with that edge is not taken
    start_ok    = START & armed;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      idx      <= 2'd0;
      cnt      <= 4'd0;
      armed    <= 1'b0;
      A        <= 1'b0;
      B        <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      PASS     <= 1'b0;
      FAIL     <= 1'b0;
      ERR_VEC  <= 4'd0;
      ERR_BITS <= 6'd0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= DRIVE;
            idx   <= 2'd0;
            BUSY  <= 1'b1;
          end
        end
        DRIVE: begin
          A     <= idx[1];
          B     <= idx[0];
          cnt   <= SETTLE_LOAD;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == 4'd0) state <= CHECK;
          else cnt <= cnt - 4'd1;
        end
        CHECK: begin
          ERR_VEC  <= err_vec_nxt;
          ERR_BITS <= ERR_BITS | diff;
          if (idx == 2'd3) begin
            state <= FINISH;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= ~|err_vec_nxt;
            FAIL  <= |err_vec_nxt;
          end else begin
            idx   <= idx + 2'd1;
            state <= DRIVE;
          end
        end
        FINISH: begin
          if (start_ok || LOOP) begin
            state    <= DRIVE;
            idx      <= 2'd0;
            BUSY     <= 1'b1;
            DONE     <= 1'b0;
            PASS     <= 1'b0;
            FAIL     <= 1'b0;
            ERR_VEC  <= 4'd0;
            ERR_BITS <= 6'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gates_selftest.sv
// Bench for gates_selftest: fault-table sweeps, randomized fault injection with
// LEDR noise outside the sampling window, reset corner cases and LOOP mode.
`timescale 1ns/1ps
module tb_gates_selftest;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, start, start_l;
  logic [5:0] ledr, ledr_l, g0;
  logic       a, b, busy, done, pass, fail;
  logic [3:0] err_vec;
  logic [5:0] err_bits;
  logic       a_l, b_l, busy_l, done_l, pass_l, fail_l;
  logic [3:0] err_vec_l;
  logic [5:0] err_bits_l;

  gates_selftest #(.SETTLE_CYCLES(2), .LOOP(1'b0)) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .START(start), .LEDR(ledr),
    .A(a), .B(b), .BUSY(busy), .DONE(done), .PASS(pass), .FAIL(fail),
    .ERR_VEC(err_vec), .ERR_BITS(err_bits));

  gates_selftest #(.SETTLE_CYCLES(1), .LOOP(1'b1)) dut_loop (
    .CLOCK_50(clk), .RESET_N(rst_n), .START(start_l), .LEDR(ledr_l),
    .A(a_l), .B(b_l), .BUSY(busy_l), .DONE(done_l), .PASS(pass_l), .FAIL(fail_l),
    .ERR_VEC(err_vec_l), .ERR_BITS(err_bits_l));

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the external gates block, with selectable faults
  int         mode;
  logic [5:0] flip [4];
  logic       noise_en;
  logic [5:0] noise_val;

  function automatic logic [5:0] gates(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), x | y, x & y};
  endfunction

  assign g0     = gates(a, b);
  assign ledr_l = gates(a_l, b_l);

  always_comb begin
    case (mode)
      1:       ledr = {g0[5], 1'b0, g0[3:0]};
      2:       ledr = {g0[5:1], g0[1]};
      3:       ledr = {g0[5:3], 1'b1, g0[1:0]};
      4:       ledr = {~g0[5], g0[4:0]};
      5:       ledr = {g0[5:4], 1'b0, g0[2:0]};
      6:       ledr = g0 ^ flip[{a, b}];
      default: ledr = g0;
    endcase
    if (noise_en) ledr = noise_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One sweep on the SETTLE_CYCLES=2 instance; CHECK occupies cycle 4k+3 of the sweep
  task automatic run_sweep(input string tag, input int extra_at, input bit noisy,
                           input logic [3:0] exp_vec, input logic [5:0] exp_bits);
    int n;
    int lat;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    lat = -1;
    check({tag, ":cleared_on_drive"}, {busy, done, pass, fail, err_vec, err_bits},
          {1'b1, 3'b000, 4'h0, 6'h00});
    while (n < 40) begin
      if (noisy && (n % 4) != 3) begin
        noise_en  = 1'b1;
        noise_val = 6'($urandom);
      end else begin
        noise_en = 1'b0;
      end
      start = (n == extra_at);
      if ((n % 4) == 3 && n < 16) check({tag, ":ab_step"}, {a, b}, n / 4);
      if (n == 15) check({tag, ":busy_before_done"}, {busy, done}, 2'b10);
      @(posedge clk);
      @(negedge clk);
      n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    noise_en = 1'b0;
    start    = 1'b0;
    check({tag, ":latency"}, lat, 16);
    check({tag, ":busy_done"}, {busy, done}, 2'b01);
    check({tag, ":pass_fail"}, {pass, fail}, (exp_vec == 4'h0) ? 2'b10 : 2'b01);
    check({tag, ":err_vec"}, err_vec, exp_vec);
    check({tag, ":err_bits"}, err_bits, exp_bits);
  endtask

  typedef struct {
    int         mode;
    logic [3:0] vec;
    logic [5:0] bits;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] ev;
    logic [5:0] eb;
    int         n;

    tbl[0] = '{0, 4'b0000, 6'b000000};
    tbl[1] = '{1, 4'b0110, 6'b010000};
    tbl[2] = '{3, 4'b1000, 6'b000100};
    tbl[3] = '{4, 4'b1111, 6'b100000};
    tbl[4] = '{5, 4'b0001, 6'b001000};
    tbl[5] = '{2, 4'b0110, 6'b000001};

    rst_n = 1'b0; start = 1'b0; start_l = 1'b0;
    mode = 0; noise_en = 1'b0; noise_val = 6'd0;
    for (int v = 0; v < 4; v++) flip[v] = 6'd0;
    #5;
    check("reset_outputs", {a, b, busy, done, pass, fail, err_vec, err_bits}, 0);
    check("reset_outputs_loop", {a_l, b_l, busy_l, done_l, pass_l, fail_l, err_vec_l, err_bits_l}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_without_start", {busy, done}, 2'b00);

    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].mode;
      run_sweep($sformatf("tbl%0d", i), -1, 1'b0, tbl[i].vec, tbl[i].bits);
    end
    // second START on the AND-wired-to-OR fault: cleared, then same results
    run_sweep("and_or_again", -1, 1'b0, 4'b0110, 6'b000001);

    mode = 0;
    run_sweep("start_while_busy", 5, 1'b0, 4'b0000, 6'b000000);
    repeat (3) @(negedge clk);
    check("no_extra_sweep", {busy, done, pass}, 3'b011);

    mode = 6;
    for (int r = 0; r < 20; r++) begin
      ev = 4'd0;
      eb = 6'd0;
      for (int v = 0; v < 4; v++) begin
        flip[v] = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
        if (flip[v] != 6'd0) ev[v] = 1'b1;
        eb = eb | flip[v];
      end
      run_sweep($sformatf("rnd%0d", r), -1, 1'b1, ev, eb);
    end

    // reset pulse during SETTLE of vector 2
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_reset_midsweep", {a, b, busy}, 3'b101);
    #1 rst_n = 1'b0;
    #1 check("async_reset_clears", {a, b, busy, done, pass, fail, err_vec, err_bits}, 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_abort", {a, b, busy, done}, 4'b0000);

    // START coincident with the reset release edge
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("start_on_release_ignored", {busy, done}, 2'b00);
    run_sweep("after_release", -1, 1'b0, 4'b0000, 6'b000000);

    // LOOP instance: DONE for one cycle every 13 cycles, PASS with it
    @(negedge clk);
    start_l = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_l = 1'b0;
    n = 0;
    while (n < 55) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n >= 12 && ((n - 12) % 13) == 0) begin
        check($sformatf("loop_done_c%0d", n), {done_l, pass_l, fail_l, busy_l}, 4'b1100);
      end else begin
        check($sformatf("loop_done_c%0d", n), done_l, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
